// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared opcode encodings, controller state encoding and opcode class helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_redirect_ctrl_pkg;

  // RISC-V major opcodes, instruction bits [6:2]
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef enum logic [1:0] {
    BRC_IDLE  = 2'd0,
    BRC_REDIR = 2'd1,
    BRC_FLUSH = 2'd2,
    BRC_EXC   = 2'd3
  } brc_state_t;

  function automatic logic is_branch_opc(input logic [4:0] opc);
    return (opc == OPC_BRANCH);
  endfunction

  function automatic logic is_jump_opc(input logic [4:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_stats.sv
// Statistics counters for resolved control-flow results (compiled only with BRANCH_STATS_EN).
// Latency: counters update one cycle after the increment enable is seen.
// Backpressure: none; enables are single-cycle handshake qualifiers from the controller.
// Ports: i_clk/i_reset, four increment enables, four CNT_W wrapping counters out.
`ifdef BRANCH_STATS_EN
module branch_redirect_ctrl_stats #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc_branches,
  input  logic             i_inc_taken,
  input  logic             i_inc_jumps,
  input  logic             i_inc_misaligned,
  output logic [CNT_W-1:0] o_stat_branches,
  output logic [CNT_W-1:0] o_stat_taken,
  output logic [CNT_W-1:0] o_stat_jumps,
  output logic [CNT_W-1:0] o_stat_misaligned
);

  logic [CNT_W-1:0] r_branches;
  logic [CNT_W-1:0] r_taken;
  logic [CNT_W-1:0] r_jumps;
  logic [CNT_W-1:0] r_misaligned;

  // Counters wrap naturally at 2^CNT_W
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branches   <= '0;
      r_taken      <= '0;
      r_jumps      <= '0;
      r_misaligned <= '0;
    end else begin
      if (i_inc_branches)   r_branches   <= r_branches + 1'b1;
      if (i_inc_taken)      r_taken      <= r_taken + 1'b1;
      if (i_inc_jumps)      r_jumps      <= r_jumps + 1'b1;
      if (i_inc_misaligned) r_misaligned <= r_misaligned + 1'b1;
    end
  end

  assign o_stat_branches   = r_branches;
  assign o_stat_taken      = r_taken;
  assign o_stat_jumps      = r_jumps;
  assign o_stat_misaligned = r_misaligned;

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// Sequences fetch redirect, timed IF/ID flush and misaligned-target exceptions after branch resolution.
// Latency: accept at N -> redirect or exception visible at N+1; all outputs registered.
// Backpressure: o_res_ready low outside IDLE; redirect held with stable PC until i_redirect_ready.
// Ports: resolution input (valid/ready, opcode, taken, pc, target), redirect to fetch (valid/ready, pc),
//        stall/flush to pipeline, misaligned exception (pulse, pc, addr).
//        BRANCH_STATS_EN adds o_stat_branches/taken/jumps/misaligned counters.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_res_valid,
  output logic            o_res_ready,
  input  logic [4:0]      i_opcode_6_to_2,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_res_pc,
  input  logic [XLEN-1:0] i_res_target,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_misaligned_exc,
  output logic [XLEN-1:0] o_exc_pc,
  output logic [XLEN-1:0] o_exc_addr
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] o_stat_branches,
  output logic [CNT_W-1:0] o_stat_taken,
  output logic [CNT_W-1:0] o_stat_jumps,
  output logic [CNT_W-1:0] o_stat_misaligned
`endif
);

  if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_param_check
    $error("branch_redirect_ctrl: parameter out of range");
  end

  localparam logic [3:0] LP_FLUSH_CYCLES = 4'(FLUSH_CYCLES);

  brc_state_t      r_state;
  logic [3:0]      r_flush_cnt;
  logic            r_res_ready;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_stall;
  logic            r_flush;
  logic            r_misaligned_exc;
  logic [XLEN-1:0] r_exc_pc;
  logic [XLEN-1:0] r_exc_addr;

  logic w_is_branch;
  logic w_is_jump;
  logic w_take;
  logic w_misaligned;
  logic w_accept;

  assign w_is_branch  = is_branch_opc(i_opcode_6_to_2);
  assign w_is_jump    = is_jump_opc(i_opcode_6_to_2);
  assign w_take       = i_branch_taken && (w_is_branch || w_is_jump);
  assign w_misaligned = (i_res_target[1:0] != 2'b00);
  // r_res_ready is only ever set in IDLE, so this is the IDLE-state handshake
  assign w_accept     = i_res_valid && r_res_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= BRC_IDLE;
      r_flush_cnt      <= '0;
      r_res_ready      <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_stall          <= 1'b0;
      r_flush          <= 1'b0;
      r_misaligned_exc <= 1'b0;
      r_exc_pc         <= '0;
      r_exc_addr       <= '0;
    end else begin
      case (r_state)
        BRC_IDLE: begin
          r_res_ready <= 1'b1;
          if (w_accept && w_take) begin
            r_res_ready <= 1'b0;
            if (w_misaligned) begin
              r_state          <= BRC_EXC;
              r_misaligned_exc <= 1'b1;
              r_exc_pc         <= i_res_pc;
              r_exc_addr       <= i_res_target;
            end else begin
              r_state          <= BRC_REDIR;
              r_redirect_valid <= 1'b1;
              r_stall          <= 1'b1;
              r_redirect_pc    <= i_res_target;
            end
          end
        end
        BRC_REDIR: begin
          if (i_redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_stall          <= 1'b0;
            if (LP_FLUSH_CYCLES == 4'd0) begin
              r_state     <= BRC_IDLE;
              r_res_ready <= 1'b1;
            end else begin
              r_state     <= BRC_FLUSH;
              r_flush     <= 1'b1;
              r_flush_cnt <= LP_FLUSH_CYCLES;
            end
          end
        end
        BRC_FLUSH: begin
          // Count reaches 1 on the last flush cycle; ready rises with the return to IDLE
          if (r_flush_cnt == 4'd1) begin
            r_state     <= BRC_IDLE;
            r_flush     <= 1'b0;
            r_flush_cnt <= '0;
            r_res_ready <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        BRC_EXC: begin
          r_state          <= BRC_IDLE;
          r_misaligned_exc <= 1'b0;
          r_res_ready      <= 1'b1;
        end
        default: begin
          r_state <= BRC_IDLE;
        end
      endcase
    end
  end

  assign o_res_ready      = r_res_ready;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_stall          = r_stall;
  assign o_flush          = r_flush;
  assign o_misaligned_exc = r_misaligned_exc;
  assign o_exc_pc         = r_exc_pc;
  assign o_exc_addr       = r_exc_addr;

`ifdef BRANCH_STATS_EN
  branch_redirect_ctrl_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_inc_branches    (w_accept && w_is_branch),
    .i_inc_taken       (w_accept && w_is_branch && w_take),
    .i_inc_jumps       (w_accept && w_is_jump),
    .i_inc_misaligned  (w_accept && w_take && w_misaligned),
    .o_stat_branches   (o_stat_branches),
    .o_stat_taken      (o_stat_taken),
    .o_stat_jumps      (o_stat_jumps),
    .o_stat_misaligned (o_stat_misaligned)
  );
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table plus hand sequences for stall/reset corners.
// Latency: n/a.
// Backpressure: drives i_redirect_ready low for the held-redirect sequence.
module tb_branch_redirect_ctrl;

  localparam logic [4:0] T_BRANCH = 5'b11000;
  localparam logic [4:0] T_JALR   = 5'b11001;
  localparam logic [4:0] T_JAL    = 5'b11011;
  localparam logic [4:0] T_OP     = 5'b01100;

  logic        clk;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  opcode;
  logic        taken;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        flush;
  logic        misaligned_exc;
  logic [31:0] exc_pc;
  logic [31:0] exc_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
  logic [31:0] stat_jumps;
  logic [31:0] stat_misaligned;
`endif

  branch_redirect_ctrl dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_res_valid      (res_valid),
    .o_res_ready      (res_ready),
    .i_opcode_6_to_2  (opcode),
    .i_branch_taken   (taken),
    .i_res_pc         (res_pc),
    .i_res_target     (res_target),
    .o_redirect_valid (redirect_valid),
    .i_redirect_ready (redirect_ready),
    .o_redirect_pc    (redirect_pc),
    .o_stall          (stall),
    .o_flush          (flush),
    .o_misaligned_exc (misaligned_exc),
    .o_exc_pc         (exc_pc),
    .o_exc_addr       (exc_addr)
`ifdef BRANCH_STATS_EN
    ,
    .o_stat_branches   (stat_branches),
    .o_stat_taken      (stat_taken),
    .o_stat_jumps      (stat_jumps),
    .o_stat_misaligned (stat_misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  opc;
    logic        tkn;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exp_redir;
    logic        exp_exc;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_pc  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one result with i_redirect_ready held high and follows it back to IDLE
  task automatic run_vec(input vec_t v, input int idx);
    int waited;
    waited = 0;
    while (!res_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk($sformatf("v%0d_ready_before", idx), 32'(res_ready), 32'd1);
    opcode     = v.opc;
    taken      = v.tkn;
    res_pc     = v.pc;
    res_target = v.tgt;
    res_valid  = 1'b1;
    tick();
    res_valid = 1'b0;
    chk($sformatf("v%0d_redirect_valid", idx), 32'(redirect_valid), 32'(v.exp_redir));
    chk($sformatf("v%0d_stall", idx), 32'(stall), 32'(v.exp_redir));
    chk($sformatf("v%0d_misaligned", idx), 32'(misaligned_exc), 32'(v.exp_exc));
    chk($sformatf("v%0d_flush_n1", idx), 32'(flush), 32'd0);
    chk($sformatf("v%0d_ready_n1", idx), 32'(res_ready), 32'(!(v.exp_redir || v.exp_exc)));
    if (v.exp_redir) begin
      chk($sformatf("v%0d_redirect_pc", idx), redirect_pc, v.tgt);
      last_pc = v.tgt;
      tick();
      chk($sformatf("v%0d_flush_n2", idx), 32'(flush), 32'd1);
      chk($sformatf("v%0d_redirect_valid_n2", idx), 32'(redirect_valid), 32'd0);
      chk($sformatf("v%0d_stall_n2", idx), 32'(stall), 32'd0);
      tick();
      chk($sformatf("v%0d_flush_n3", idx), 32'(flush), 32'd1);
      chk($sformatf("v%0d_ready_n3", idx), 32'(res_ready), 32'd0);
      tick();
      chk($sformatf("v%0d_flush_n4", idx), 32'(flush), 32'd0);
      chk($sformatf("v%0d_ready_n4", idx), 32'(res_ready), 32'd1);
    end else if (v.exp_exc) begin
      chk($sformatf("v%0d_exc_addr", idx), exc_addr, v.tgt);
      chk($sformatf("v%0d_exc_pc", idx), exc_pc, v.pc);
      chk($sformatf("v%0d_redirect_pc_kept", idx), redirect_pc, last_pc);
      tick();
      chk($sformatf("v%0d_misaligned_n2", idx), 32'(misaligned_exc), 32'd0);
      chk($sformatf("v%0d_flush_n2", idx), 32'(flush), 32'd0);
      chk($sformatf("v%0d_ready_n2", idx), 32'(res_ready), 32'd1);
    end else begin
      chk($sformatf("v%0d_redirect_pc_kept", idx), redirect_pc, last_pc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_misaligned"}, 32'(misaligned_exc), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    chk({tag, "_exc_pc"}, exc_pc, 32'h0);
    chk({tag, "_exc_addr"}, exc_addr, 32'h0);
  endtask

  initial begin
    //             opc       tkn   pc             tgt            redir exc
    vecs[0] = '{T_BRANCH, 1'b0, 32'h0000_0010, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{T_BRANCH, 1'b1, 32'h0000_0014, 32'h0000_0100, 1'b1, 1'b0};
    vecs[2] = '{T_JALR,   1'b1, 32'h0000_0020, 32'h0000_0102, 1'b0, 1'b1};
    vecs[3] = '{T_JAL,    1'b1, 32'h0000_0024, 32'h0000_2000, 1'b1, 1'b0};
    vecs[4] = '{T_OP,     1'b1, 32'h0000_0028, 32'h0000_0040, 1'b0, 1'b0};
    vecs[5] = '{T_JAL,    1'b1, 32'h0000_002C, 32'h0000_1001, 1'b0, 1'b1};
    vecs[6] = '{T_BRANCH, 1'b1, 32'h0000_0030, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[7] = '{T_JALR,   1'b0, 32'h0000_0034, 32'h0000_0203, 1'b0, 1'b0};

    reset          = 1'b1;
    res_valid      = 1'b0;
    opcode         = 5'd0;
    taken          = 1'b0;
    res_pc         = 32'h0;
    res_target     = 32'h0;
    redirect_ready = 1'b1;

    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk("post_reset_ready", 32'(res_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Held redirect: fetch refuses for 5 cycles while a second result waits
    redirect_ready = 1'b0;
    opcode         = T_BRANCH;
    taken          = 1'b1;
    res_pc         = 32'h0000_0200;
    res_target     = 32'h8000_0000;
    res_valid      = 1'b1;
    tick();
    taken      = 1'b0;
    res_pc     = 32'h0000_0204;
    res_target = 32'h0000_0300;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_redirect_valid", i), 32'(redirect_valid), 32'd1);
      chk($sformatf("hold%0d_stall", i), 32'(stall), 32'd1);
      chk($sformatf("hold%0d_redirect_pc", i), redirect_pc, 32'h8000_0000);
      chk($sformatf("hold%0d_res_ready", i), 32'(res_ready), 32'd0);
      if (i == 4) redirect_ready = 1'b1;
      tick();
    end
    chk("hold_flush_a", 32'(flush), 32'd1);
    chk("hold_redirect_dropped", 32'(redirect_valid), 32'd0);
    tick();
    chk("hold_flush_b", 32'(flush), 32'd1);
    tick();
    chk("hold_flush_end", 32'(flush), 32'd0);
    chk("hold_ready_back", 32'(res_ready), 32'd1);
    tick();
    res_valid = 1'b0;
    last_pc   = 32'h8000_0000;
    chk("held_result_no_redirect", 32'(redirect_valid), 32'd0);
    chk("held_result_ready", 32'(res_ready), 32'd1);
    chk("held_result_pc_kept", redirect_pc, last_pc);

    // Reset while a redirect is pending
    redirect_ready = 1'b0;
    opcode         = T_JAL;
    taken          = 1'b1;
    res_pc         = 32'h0000_0400;
    res_target     = 32'h0000_0500;
    res_valid      = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("rst_redir_pending", 32'(redirect_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_redir");
    reset = 1'b0;
    tick();
    chk("rst_redir_ready_after", 32'(res_ready), 32'd1);
    chk("rst_redir_no_valid", 32'(redirect_valid), 32'd0);

    // Reset in the middle of a flush
    redirect_ready = 1'b1;
    opcode         = T_BRANCH;
    res_target     = 32'h0000_0600;
    res_valid      = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    chk("rst_flush_active", 32'(flush), 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_flush");
    reset = 1'b0;
    tick();
    chk("rst_flush_ready_after", 32'(res_ready), 32'd1);
    last_pc = 32'h0;

`ifdef BRANCH_STATS_EN
    chk("stat_branches_reset", stat_branches, 32'd0);
    for (int i = 0; i < 3; i++)
      run_vec('{T_BRANCH, 1'b1, 32'h0000_0700 + 32'(i * 4), 32'h0000_0800 + 32'(i * 16), 1'b1, 1'b0}, 10 + i);
    for (int i = 0; i < 2; i++)
      run_vec('{T_BRANCH, 1'b0, 32'h0000_0710 + 32'(i * 4), 32'h0000_0900, 1'b0, 1'b0}, 13 + i);
    run_vec('{T_JAL, 1'b1, 32'h0000_0720, 32'h0000_0A00, 1'b1, 1'b0}, 15);
    chk("stat_branches", stat_branches, 32'd5);
    chk("stat_taken", stat_taken, 32'd3);
    chk("stat_jumps", stat_jumps, 32'd1);
    chk("stat_misaligned", stat_misaligned, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
